// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for imem_loader.
// master drives the stream and observes writes; slave is the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_last;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_byte, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_byte, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into instruction memory and holds the core in reset.
// Optional trailer checksum over all written words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  imem_loader_if.slave    io_bus,
  output logic            o_cpu_reset,
  output logic            o_done,
  output logic            o_error,
  output logic [ADDR_W:0] o_word_count
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    StLoad,
    StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDoneHold,
    StRun,
    StErr
  } state_e;

  state_e            r_state;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [HoldW-1:0]  r_hold;
  logic              r_last;
  logic              r_we;
  logic              r_cpu_reset;
  logic              r_done;
  logic              r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       r_sum;
`endif

  logic w_in_ready;
  logic w_accept;

  // Ready is decoded combinationally so it drops in the very cycle reset is asserted.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_in_ready = !i_reset && (r_state == StLoad || r_state == StCheck);
`else
  assign w_in_ready = !i_reset && (r_state == StLoad);
`endif
  assign w_accept = io_bus.in_valid && w_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StLoad;
      r_idx       <= 2'd0;
      r_word      <= 32'd0;
      r_addr      <= '0;
      r_count     <= '0;
      r_hold      <= '0;
      r_last      <= 1'b0;
      r_we        <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= 32'd0;
`endif
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        StLoad: begin
          if (w_accept) begin
            r_word <= {r_word[23:0], io_bus.in_byte};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= StWrite;
              r_we    <= 1'b1;
              r_last  <= io_bus.in_last;
            end else if (io_bus.in_last) begin
              r_state <= StErr;
              r_error <= 1'b1;
            end
          end
        end
        StWrite: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_count < (ADDR_W + 1)'(DEPTH_WORDS)) r_count <= r_count + (ADDR_W + 1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_sum <= r_sum + r_word;
`endif
          if (r_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state <= StCheck;
`else
            r_state <= StDoneHold;
            r_hold  <= '0;
`endif
          end else if (r_addr == ADDR_W'(DEPTH_WORDS - 1)) begin
            r_state <= StErr;
            r_error <= 1'b1;
          end else begin
            r_state <= StLoad;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck: begin
          // in_last is deliberately ignored here; the trailer is always exactly four bytes.
          if (w_accept) begin
            r_word <= {r_word[23:0], io_bus.in_byte};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if ({r_word[23:0], io_bus.in_byte} == r_sum) begin
                r_state <= StDoneHold;
                r_hold  <= '0;
              end else begin
                r_state <= StErr;
                r_error <= 1'b1;
              end
            end
          end
        end
`endif
        StDoneHold: begin
          if (r_hold == HoldW'(HOLD_CYCLES - 1)) begin
            r_state     <= StRun;
            r_cpu_reset <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_hold <= r_hold + HoldW'(1);
          end
        end
        StRun: r_state <= StRun;
        StErr: r_state <= StErr;
        default: begin
          r_state <= StErr;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.imem_we    = r_we;
  assign io_bus.imem_addr  = r_addr;
  assign io_bus.imem_wdata = r_word;
  assign o_cpu_reset       = r_cpu_reset;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_word_count      = r_count;

endmodule
